// File: rtl/alarm_unit.sv
// Alarm controller fed by a 12-hour BCD time counter: stores an alarm time,
// rings on the match edge, and handles snooze. Optional auto-silence: ALARM_AUTO_SILENCE_EN.
//
// state   | meaning
// IDLE    | disarmed, alarm time may be set
// ARMED   | waiting for a rising match of time vs alarm
// RINGING | ring asserted until snooze or disarm (or auto-silence)
// SNOOZE  | counting 300 ena ticks before ringing again
module alarm_unit (
   input  logic       clk,
   input  logic       reset,
   input  logic       ena,
   input  logic [7:0] hh,
   input  logic [7:0] mm,
   input  logic [7:0] ss,
   input  logic       pm,
   input  logic       set_valid,
   input  logic [7:0] set_hh,
   input  logic [7:0] set_mm,
   input  logic       set_pm,
   output logic       set_ready,
   input  logic       arm,
   input  logic       disarm,
   input  logic       snooze,
   output logic       ring,
   output logic       armed,
   output logic       snoozing,
   output logic       set_err,
   output logic [1:0] snooze_left,
   output logic [7:0] alarm_hh,
   output logic [7:0] alarm_mm,
   output logic       alarm_pm
);

   typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;

   state_t     state;
   state_t     state_nxt;
   logic       match;
   logic       match_d;
   logic [8:0] snz_tmr;
   logic       xfer;
   logic       set_ok;
   logic       hh_ok;
   logic       mm_ok;
   logic       snooze_go;
   logic       snooze_done;
   logic       silence;
`ifdef ALARM_AUTO_SILENCE_EN
   logic [5:0] sil_cnt;
`endif

   assign match = ({pm, hh, mm, ss} == {alarm_pm, alarm_hh, alarm_mm, 8'h00});
   assign xfer  = set_valid && set_ready;

   // Hours 01..12 and minutes 00..59, both as legal packed BCD.
   assign hh_ok  = (set_hh == 8'h10) || (set_hh == 8'h11) || (set_hh == 8'h12) ||
                   ((set_hh[7:4] == 4'd0) && (set_hh[3:0] >= 4'd1) && (set_hh[3:0] <= 4'd9));
   assign mm_ok  = (set_mm[7:4] <= 4'd5) && (set_mm[3:0] <= 4'd9);
   assign set_ok = hh_ok && mm_ok;

   assign snooze_go   = (state == RINGING) && snooze && (snooze_left != 2'd0);
   assign snooze_done = (state == SNOOZE) && ena && (snz_tmr == 9'd1);
`ifdef ALARM_AUTO_SILENCE_EN
   assign silence = (state == RINGING) && ena && (sil_cnt == 6'd59);
`else
   assign silence = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      if (disarm) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (arm) state_nxt = ARMED;
            ARMED:   if (match && !match_d) state_nxt = RINGING;
            RINGING: begin
               if (snooze_go)    state_nxt = SNOOZE;
               else if (silence) state_nxt = ARMED;
            end
            SNOOZE:  if (snooze_done) state_nxt = RINGING;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         ring        <= 1'b0;
         armed       <= 1'b0;
         snoozing    <= 1'b0;
         set_err     <= 1'b0;
         set_ready   <= 1'b1;
         snooze_left <= 2'd3;
         snz_tmr     <= 9'd0;
         match_d     <= 1'b0;
         alarm_hh    <= 8'h12;
         alarm_mm    <= 8'h00;
         alarm_pm    <= 1'b0;
`ifdef ALARM_AUTO_SILENCE_EN
         sil_cnt     <= 6'd0;
`endif
      end else begin
         state     <= state_nxt;
         ring      <= (state_nxt == RINGING);
         armed     <= (state_nxt != IDLE);
         snoozing  <= (state_nxt == SNOOZE);
         set_ready <= (state_nxt == IDLE) || (state_nxt == ARMED);
         match_d   <= match;
         set_err   <= xfer && !set_ok;

         if (xfer && set_ok) begin
            alarm_hh <= set_hh;
            alarm_mm <= set_mm;
            alarm_pm <= set_pm;
         end

         if (disarm || silence)
            snooze_left <= 2'd3;
         else if (snooze_go)
            snooze_left <= snooze_left - 2'd1;

         if (disarm)
            snz_tmr <= 9'd0;
         else if (snooze_go)
            snz_tmr <= 9'd300;
         else if ((state == SNOOZE) && ena && (snz_tmr != 9'd0))
            snz_tmr <= snz_tmr - 9'd1;

`ifdef ALARM_AUTO_SILENCE_EN
         if ((state_nxt == RINGING) && (state != RINGING))
            sil_cnt <= 6'd0;
         else if ((state == RINGING) && ena)
            sil_cnt <= sil_cnt + 6'd1;
`endif
      end
   end

endmodule

// File: tb/tb_alarm_unit.sv
// Directed bench for alarm_unit: set/arm/ring, snooze exhaustion, bad sets,
// arm+disarm priority, async reset mid-snooze and the auto-silence option.
module tb_alarm_unit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ena = 1'b0;
   logic [7:0] hh = 8'h00, mm = 8'h00, ss = 8'h00;
   logic       pm = 1'b0;
   logic       set_valid = 1'b0;
   logic [7:0] set_hh = 8'h00, set_mm = 8'h00;
   logic       set_pm = 1'b0;
   logic       arm = 1'b0, disarm = 1'b0, snooze = 1'b0;
   logic       set_ready, ring, armed, snoozing, set_err, alarm_pm;
   logic [1:0] snooze_left;
   logic [7:0] alarm_hh, alarm_mm;

   int errors = 0;
   int checks = 0;

   alarm_unit dut (
      .clk(clk), .reset(reset), .ena(ena), .hh(hh), .mm(mm), .ss(ss), .pm(pm),
      .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm), .set_pm(set_pm),
      .set_ready(set_ready), .arm(arm), .disarm(disarm), .snooze(snooze),
      .ring(ring), .armed(armed), .snoozing(snoozing), .set_err(set_err),
      .snooze_left(snooze_left), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
      .alarm_pm(alarm_pm)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic p);
      hh = h; mm = m; ss = s; pm = p;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".ring"},     32'(ring), 0);
      chk({tag, ".armed"},    32'(armed), 0);
      chk({tag, ".snoozing"}, 32'(snoozing), 0);
      chk({tag, ".set_err"},  32'(set_err), 0);
      chk({tag, ".ready"},    32'(set_ready), 1);
      chk({tag, ".left"},     32'(snooze_left), 3);
      chk({tag, ".hh"},       32'(alarm_hh), 'h12);
      chk({tag, ".mm"},       32'(alarm_mm), 'h00);
      chk({tag, ".pm"},       32'(alarm_pm), 0);
   endtask

   initial begin
      // Reset values
      step(3);
      chk_reset_vals("rst");
      reset = 1'b0;
      step(2);
      chk("post_rst.ring", 32'(ring), 0);

      // Set 06:30 AM in IDLE
      set_hh = 8'h06; set_mm = 8'h30; set_pm = 1'b0; set_valid = 1'b1;
      step();
      set_valid = 1'b0;
      chk("set1.hh", 32'(alarm_hh), 'h06);
      chk("set1.mm", 32'(alarm_mm), 'h30);
      chk("set1.err", 32'(set_err), 0);
      chk("set1.armed", 32'(armed), 0);

      // Arm with time one second before the alarm
      set_time(8'h06, 8'h29, 8'h59, 1'b0);
      arm = 1'b1;
      step();
      arm = 1'b0;
      chk("arm.armed", 32'(armed), 1);
      chk("arm.ring", 32'(ring), 0);
      chk("arm.ready", 32'(set_ready), 1);

      // Time reaches the alarm: ring one clk later
      set_time(8'h06, 8'h30, 8'h00, 1'b0);
      ena = 1'b1;
      step();
      ena = 1'b0;
      chk("match.ring", 32'(ring), 1);
      chk("match.ready", 32'(set_ready), 0);

      // A held match must not retrigger anything; set while ringing ignored
      set_valid = 1'b1; set_hh = 8'h07; set_mm = 8'h00;
      step();
      set_valid = 1'b0;
      chk("ring_set.ready", 32'(set_ready), 0);
      chk("ring_set.hh", 32'(alarm_hh), 'h06);
      chk("ring_set.err", 32'(set_err), 0);
      chk("ring_set.ring", 32'(ring), 1);

      // Three snoozes, each returning to RINGING after 300 ena ticks
      for (int k = 0; k < 3; k++) begin
         snooze = 1'b1;
         step();
         snooze = 1'b0;
         chk("snz.snoozing", 32'(snoozing), 1);
         chk("snz.ring", 32'(ring), 0);
         chk("snz.left", 32'(snooze_left), 32'(2 - k));
         ena = 1'b1;
         step(299);
         chk("snz299.snoozing", 32'(snoozing), 1);
         step();
         ena = 1'b0;
         chk("snz300.ring", 32'(ring), 1);
         chk("snz300.snoozing", 32'(snoozing), 0);
      end

      // Fourth snooze is ignored
      snooze = 1'b1;
      step();
      snooze = 1'b0;
      chk("snz4.ring", 32'(ring), 1);
      chk("snz4.snoozing", 32'(snoozing), 0);
      chk("snz4.left", 32'(snooze_left), 0);

`ifdef ALARM_AUTO_SILENCE_EN
      ena = 1'b1;
      step(59);
      chk("sil59.ring", 32'(ring), 1);
      step();
      ena = 1'b0;
      chk("sil60.ring", 32'(ring), 0);
      chk("sil60.armed", 32'(armed), 1);
      chk("sil60.left", 32'(snooze_left), 3);
`else
      ena = 1'b1;
      step(1000);
      ena = 1'b0;
      chk("noauto.ring", 32'(ring), 1);
      chk("noauto.armed", 32'(armed), 1);
`endif

      // arm+disarm together from RINGING (or ARMED with auto-silence)
      arm = 1'b1; disarm = 1'b1;
      step();
      arm = 1'b0; disarm = 1'b0;
      chk("ad_ring.ring", 32'(ring), 0);
      chk("ad_ring.armed", 32'(armed), 0);
      chk("ad_ring.left", 32'(snooze_left), 3);

      // Bad hour: rejected with one-cycle set_err
      set_valid = 1'b1; set_hh = 8'h13; set_mm = 8'h00;
      step();
      set_valid = 1'b0;
      chk("bad_hh.err", 32'(set_err), 1);
      chk("bad_hh.hh", 32'(alarm_hh), 'h06);
      step();
      chk("bad_hh.err_clr", 32'(set_err), 0);

      // Bad minute
      set_valid = 1'b1; set_hh = 8'h07; set_mm = 8'h60;
      step();
      set_valid = 1'b0;
      chk("bad_mm.err", 32'(set_err), 1);
      chk("bad_mm.hh", 32'(alarm_hh), 'h06);
      chk("bad_mm.mm", 32'(alarm_mm), 'h30);

      // Hour 00 is not a 12-hour value
      set_valid = 1'b1; set_hh = 8'h00; set_mm = 8'h15;
      step();
      set_valid = 1'b0;
      chk("bad_h00.err", 32'(set_err), 1);
      chk("bad_h00.mm", 32'(alarm_mm), 'h30);

      // arm+disarm together in IDLE
      arm = 1'b1; disarm = 1'b1;
      step();
      arm = 1'b0; disarm = 1'b0;
      chk("ad_idle.armed", 32'(armed), 0);
      chk("ad_idle.ring", 32'(ring), 0);

      // Transfer and arm in the same cycle, boundary 12:59 PM
      set_time(8'h12, 8'h58, 8'h59, 1'b1);
      set_valid = 1'b1; set_hh = 8'h12; set_mm = 8'h59; set_pm = 1'b1;
      arm = 1'b1;
      step();
      set_valid = 1'b0; arm = 1'b0;
      chk("xarm.armed", 32'(armed), 1);
      chk("xarm.hh", 32'(alarm_hh), 'h12);
      chk("xarm.mm", 32'(alarm_mm), 'h59);
      chk("xarm.pm", 32'(alarm_pm), 1);
      chk("xarm.err", 32'(set_err), 0);
      set_time(8'h12, 8'h59, 8'h00, 1'b1);
      step();
      chk("xarm.ring", 32'(ring), 1);

      // Snooze, then reset with the timer at 150
      snooze = 1'b1;
      step();
      snooze = 1'b0;
      ena = 1'b1;
      step(150);
      ena = 1'b0;
      chk("pre_rst.snoozing", 32'(snoozing), 1);
      set_time(8'h12, 8'h00, 8'h00, 1'b0);
      reset = 1'b1;
      #1;
      chk_reset_vals("async_rst");
      step();
      reset = 1'b0;
      step(3);
      chk("rel.ring", 32'(ring), 0);
      chk("rel.armed", 32'(armed), 0);

      // Arm while the match is held: no ring until a fresh match edge
      arm = 1'b1;
      step();
      arm = 1'b0;
      step(3);
      chk("held.armed", 32'(armed), 1);
      chk("held.ring", 32'(ring), 0);
      set_time(8'h12, 8'h00, 8'h01, 1'b0);
      step();
      chk("fresh_pre.ring", 32'(ring), 0);
      set_time(8'h12, 8'h00, 8'h00, 1'b0);
      step();
      chk("fresh.ring", 32'(ring), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alarm_unit.md
ALARM_UNIT -- requirements
Module: alarm_unit

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  asynchronous, active-high.
REQ-002 SHALL have time inputs from the 12-hour clock counter: ena in 1 (one-second tick); hh in 8, mm in 8, ss in 8 (packed BCD); pm in 1.
REQ-003 SHALL have set-port inputs: set_valid in 1; set_hh in 8 (BCD); set_mm in 8 (BCD); set_pm in 1. Set-port output: set_ready out 1.
REQ-004 SHALL have control inputs arm, disarm, snooze (each 1, level-sampled per clk).
REQ-005 SHALL have outputs: ring 1; armed 1; snoozing 1; set_err 1 (one-cycle pulse); snooze_left 2 (remaining snoozes); alarm_hh 8, alarm_mm 8, alarm_pm 1 (stored alarm).

Function
REQ-006 SHALL implement FSM states IDLE, ARMED, RINGING, SNOOZE; all outputs registered.
REQ-007 disarm SHALL take priority over every other input: any state -> IDLE next edge, snooze_left -> 3, snooze timer cleared.
REQ-008 IDLE: arm=1 -> ARMED. In any other state arm SHALL be ignored.
REQ-009 match = ({pm,hh,mm,ss} == {alarm_pm,alarm_hh,alarm_mm,8'h00}); match SHALL be registered into match_d each cycle.
REQ-010 ARMED: match & !match_d -> RINGING (ring asserts the cycle after the time inputs first equal the alarm time); a held match SHALL NOT retrigger.
REQ-011 RINGING: snooze=1 and snooze_left>0 -> SNOOZE, snooze timer loaded with 300, snooze_left decremented; snooze with snooze_left==0 SHALL be ignored.
REQ-012 SNOOZE: timer decrements only on ena=1; ena=1 with timer==1 -> RINGING (300 ena ticks after entry). Timer is 9 bits, SHALL never wrap below 0.
REQ-013 set_ready SHALL be 1 exactly in IDLE or ARMED; transfer occurs on set_valid & set_ready at a clk edge.
REQ-014 Accepted transfer SHALL update alarm_hh/mm/pm next edge if set_hh in BCD 01..12 and set_mm in BCD 00..59; otherwise registers unchanged and set_err pulses one cycle. State SHALL NOT change on a transfer.
REQ-015 Transfer and arm in same cycle: both take effect; the new alarm time is used for matching from the following cycle.
REQ-016 ring = (state==RINGING); armed = (state!=IDLE); snoozing = (state==SNOOZE).
REQ-017 On RINGING -> ARMED exit (see REQ-022) snooze_left SHALL reload to 3.

Reset
REQ-018 reset SHALL asynchronously force: state IDLE; ring, armed, snoozing, set_err 0; set_ready 1; snooze_left 3; snooze timer 0; match_d 0.
REQ-019 reset SHALL set alarm_hh=8'h12, alarm_mm=8'h00, alarm_pm=0 (12:00 AM).
REQ-020 Reset asserted mid-ring or mid-snooze SHALL abort immediately; no pending event survives reset.
REQ-021 Release of reset SHALL take effect at the next clk edge with no spurious ring.

Configuration
REQ-022 Macro ALARM_AUTO_SILENCE_EN: when defined, RINGING counts ena ticks (6-bit) and on the 60th tick returns to ARMED (ring drops next edge, snooze_left -> 3); counter clears on entering RINGING. When undefined, RINGING persists until snooze or disarm and no counter is built.

Verification
REQ-023 Reset, then set 06:30 AM, arm, drive time 06:29:59 AM -> 06:30:00 AM with ena -> ring=1 one clk after 06:30:00 appears; alarm_hh=8'h06, alarm_mm=8'h30.
REQ-024 Ringing, pulse snooze -> snoozing=1, snooze_left=2; after 300 ena ticks ring=1; repeat 3 snoozes -> 4th snooze ignored, ring stays 1, snooze_left=0.
REQ-025 Set with set_hh=8'h13 or set_mm=8'h60 -> set_err one-cycle pulse, alarm registers keep prior values; set_valid while RINGING -> set_ready=0, no update.
REQ-026 arm and disarm asserted together in IDLE and in RINGING -> state IDLE, ring=0, armed=0.
REQ-027 Assert reset during SNOOZE with timer=150 -> outputs at reset values immediately, alarm=12:00 AM; time held at alarm value after release -> no ring until armed and a fresh match edge.
REQ-028 With ALARM_AUTO_SILENCE_EN: ring for 60 ena ticks, no inputs -> ring=0, armed=1, snooze_left=3; without macro: ring still 1 after 1000 ticks.
